// File: rtl/pwm_dac_multi_pkg.sv
// Shared definitions for the multi-channel PWM DAC.
// Everything derived from the parameters is computed by these helpers, so the
// top level and the channel module size their registers the same way.
//   ptr_width(depth) : FIFO pointer width, index bits plus one wrap bit
//   div_width(sdiv)  : width of the sample-rate divider
//   cnt_width(width) : width of the shared period counter
//   is_pow2(v)       : FIFO depth legality check (power of two, >= 2)
package pwm_dac_multi_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int div_width(input int sdiv);
    return $clog2(sdiv) + 1;
  endfunction

  function automatic int cnt_width(input int width);
    return width;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pwm_dac_channel.sv
// One PWM DAC channel: sample FIFO, duty register, compare flop and sticky
// underrun flag. The shared period counter and the load strobe come from the
// top level so all channels switch duty on the same period boundary.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              run enable (pwm forced low when 0)
//   cnt             shared period counter
//   load            period boundary strobe: pop a sample into duty
//   wr_valid/ready  sample write handshake; push when both are 1
//   wr_data         sample written into the FIFO
//   clr_underrun    clears the underrun flag (a same-cycle set wins)
//   pwm             registered PWM output
//   underrun        sticky flag: a boundary found the FIFO empty
module pwm_dac_channel
  import pwm_dac_multi_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  input  logic             load,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             clr_underrun,
  output logic             pwm,
  output logic             underrun
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] duty;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Equal pointers mean empty; equal index with differing wrap bit means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Not ready while in reset, so nothing is pushed before the FIFO is live.
  assign wr_ready = rst_n && !full;
  assign push     = wr_valid && wr_ready;
  // Emptiness is judged before this cycle's push, so a push landing on an
  // empty FIFO at a boundary is stored but not popped.
  assign pop      = load && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      duty     <= '0;
      pwm      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        duty   <= mem[rd_ptr[AW-1:0]];
      end
      pwm <= en && (cnt < duty);
      if (load && empty) underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM audio DAC. A shared period counter (2^WIDTH cycles) and a
// sample-rate divider produce one load boundary every SAMPLE_DIV periods; at
// that boundary every channel pops its next sample into its duty register.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            run enable; when 0 counter/divider sit at 0 and pwm is low
//   wr_valid      per-channel sample valid
//   wr_data       packed samples, channel i = [i*WIDTH +: WIDTH]
//   wr_ready      per-channel FIFO not full (0 during reset)
//   clr_underrun  clears all underrun flags
//   pwm           registered PWM outputs
//   underrun      sticky per-channel underrun flags
//   sample_tick   one-cycle pulse the cycle after each load boundary
// Handshake: a sample is transferred on a clock edge where wr_valid[i] and
// wr_ready[i] are both 1; wr_ready does not depend on wr_valid.
module pwm_dac_multi
  import pwm_dac_multi_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DIV = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       wr_valid,
  input  logic [CHANNELS*WIDTH-1:0] wr_data,
  output logic [CHANNELS-1:0]       wr_ready,
  input  logic                      clr_underrun,
  output logic [CHANNELS-1:0]       pwm,
  output logic [CHANNELS-1:0]       underrun,
  output logic                      sample_tick
);

  localparam int CW = cnt_width(WIDTH);
  localparam int DW = div_width(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_LAST = '1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("pwm_dac_multi: FIFO_DEPTH must be a power of two and >= 2");
  end

  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic          load;

  assign load = en && (cnt == CNT_LAST) && (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      div         <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= load;
      if (!en) begin
        cnt <= '0;
        div <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        if (cnt == CNT_LAST) div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_dac_channel #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .cnt          (cnt),
      .load         (load),
      .wr_valid     (wr_valid[i]),
      .wr_data      (wr_data[i*WIDTH +: WIDTH]),
      .wr_ready     (wr_ready[i]),
      .clr_underrun (clr_underrun),
      .pwm          (pwm[i]),
      .underrun     (underrun[i])
    );
  end

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Directed bench for pwm_dac_multi with WIDTH=4 (16-cycle period), two
// channels, depth-4 FIFOs. A second instance uses SAMPLE_DIV=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_dac_multi;

  localparam int W  = 4;
  localparam int CH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [CH-1:0] wr_valid = '0;
  logic [CH*W-1:0] wr_data = '0;
  logic [CH-1:0] wr_ready;
  logic          clr_underrun = 1'b0;
  logic [CH-1:0] pwm;
  logic [CH-1:0] underrun;
  logic          sample_tick;

  logic          en3 = 1'b0;
  logic [CH-1:0] wr_valid3 = '0;
  logic [CH*W-1:0] wr_data3 = '0;
  logic [CH-1:0] wr_ready3;
  logic [CH-1:0] pwm3;
  logic [CH-1:0] underrun3;
  logic          tick3;

  pwm_dac_multi #(.WIDTH(W), .CHANNELS(CH), .FIFO_DEPTH(4), .SAMPLE_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .clr_underrun(clr_underrun), .pwm(pwm),
    .underrun(underrun), .sample_tick(sample_tick)
  );

  pwm_dac_multi #(.WIDTH(W), .CHANNELS(CH), .FIFO_DEPTH(4), .SAMPLE_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .wr_valid(wr_valid3), .wr_data(wr_data3),
    .wr_ready(wr_ready3), .clr_underrun(clr_underrun), .pwm(pwm3),
    .underrun(underrun3), .sample_tick(tick3)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [CH-1:0] chans, input logic [W-1:0] d0, input logic [W-1:0] d1);
    wr_valid = chans;
    wr_data  = {d1, d0};
    @(negedge clk);
    wr_valid = '0;
  endtask

  // Advance n cycles, counting high samples of pwm and sample_tick.
  task automatic run_cycles(input int n, output int h0, output int h1, output int tk);
    h0 = 0; h1 = 0; tk = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      tk += int'(sample_tick);
    end
  endtask

  task automatic stop_and_clear();
    en = 1'b0;
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int h0, h1, tk, a0, a1, at;

    // 1. reset
    @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_tick", 32'(sample_tick), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_wr_ready", 32'(wr_ready), 32'h3);

    // 2. basic duties 5 / 12
    push(2'b11, 4'd5, 4'd12);
    en = 1'b1;
    run_cycles(16, h0, h1, tk);
    check("t2_first_tick", 32'(tk), 32'd1);
    check("t2_pwm_at_boundary", 32'(pwm), 32'h0);
    run_cycles(1, a0, a1, at);
    check("t2_pwm_start", 32'(pwm), 32'h3);
    check("t2_tick_one_cycle", 32'(sample_tick), 32'h0);
    run_cycles(15, h0, h1, tk);
    check("t2_high_ch0", 32'(a0 + h0), 32'd5);
    check("t2_high_ch1", 32'(a1 + h1), 32'd12);
    check("t2_ticks_per_period", 32'(at + tk), 32'd1);
    check("t2_underrun_empty", 32'(underrun), 32'h3);
    stop_and_clear();
    check("t2_clr", 32'(underrun), 32'h0);

    // 3/4. fill ch0 with 1..4, ch1 gets a single 7
    push(2'b11, 4'd1, 4'd7);
    push(2'b01, 4'd2, 4'd0);
    push(2'b01, 4'd3, 4'd0);
    push(2'b01, 4'd4, 4'd0);
    check("t3_full_ready", 32'(wr_ready), 32'h2);
    push(2'b01, 4'd9, 4'd0);  // dropped: ch0 full
    en = 1'b1;
    run_cycles(16, h0, h1, tk);
    check("t3_ready_after_pop", 32'(wr_ready), 32'h3);
    run_cycles(16, h0, h1, tk);
    check("t3_duty1", 32'(h0), 32'd1);
    check("t3_duty7", 32'(h1), 32'd7);
    check("t4_underrun_ch1", 32'(underrun), 32'h2);
    run_cycles(16, h0, h1, tk);
    check("t3_duty2", 32'(h0), 32'd2);
    check("t4_held7", 32'(h1), 32'd7);
    check("t4_sticky", 32'(underrun), 32'h2);
    clr_underrun = 1'b1;
    run_cycles(1, a0, a1, at);
    clr_underrun = 1'b0;
    check("t4_clear", 32'(underrun), 32'h0);
    run_cycles(14, h0, h1, tk);
    a0 += h0; a1 += h1;
    clr_underrun = 1'b1;
    run_cycles(1, h0, h1, tk);
    clr_underrun = 1'b0;
    a0 += h0; a1 += h1;
    check("t4_set_beats_clr", 32'(underrun), 32'h2);
    check("t3_duty3", 32'(a0), 32'd3);
    check("t4_held7_b", 32'(a1), 32'd7);
    run_cycles(16, h0, h1, tk);
    check("t3_duty4", 32'(h0), 32'd4);
    check("t3_fifth_dropped", 32'(underrun), 32'h3);
    stop_and_clear();

    // 5. duty extremes 0 / 15
    push(2'b11, 4'd0, 4'd15);
    en = 1'b1;
    run_cycles(16, h0, h1, tk);
    run_cycles(16, h0, h1, tk);
    check("t5_duty0", 32'(h0), 32'd0);
    check("t5_duty15", 32'(h1), 32'd15);
    check("t5_tick", 32'(tk), 32'd1);
    stop_and_clear();

    // 5b. SAMPLE_DIV=3: loads every 48 cycles
    wr_valid3 = 2'b11;
    wr_data3  = {4'd6, 4'd3};
    @(negedge clk);
    wr_valid3 = '0;
    en3 = 1'b1;
    at = 0;
    for (int i = 0; i < 47; i++) begin
      @(negedge clk);
      at += int'(tick3);
    end
    check("t5_div3_no_early_tick", 32'(at), 32'd0);
    @(negedge clk);
    check("t5_div3_tick48", 32'(tick3), 32'h1);
    check("t5_div3_no_underrun", 32'(underrun3), 32'h0);
    a0 = 0; a1 = 0; at = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      a0 += int'(pwm3[0]);
      a1 += int'(pwm3[1]);
      at += int'(tick3);
    end
    check("t5_div3_ch0_3x3", 32'(a0), 32'd9);
    check("t5_div3_ch1_3x6", 32'(a1), 32'd18);
    check("t5_div3_one_tick", 32'(at), 32'd1);
    check("t5_div3_underrun", 32'(underrun3), 32'h3);
    en3 = 1'b0;

    // 6. reset mid-period with pending FIFO data
    push(2'b01, 4'd5, 4'd0);
    push(2'b01, 4'd6, 4'd0);
    en = 1'b1;
    run_cycles(18, h0, h1, tk);
    check("t6_pre_pwm0", 32'(pwm[0]), 32'h1);
    check("t6_pre_underrun", 32'(underrun), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_pwm", 32'(pwm), 32'h0);
    check("t6_async_underrun", 32'(underrun), 32'h0);
    check("t6_async_ready", 32'(wr_ready), 32'h0);
    check("t6_async_underrun3", 32'(underrun3), 32'h0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    #1;
    check("t6_ready_after_rst", 32'(wr_ready), 32'h3);
    en = 1'b1;
    run_cycles(15, h0, h1, tk);
    check("t6_no_early_underrun", 32'(underrun), 32'h0);
    check("t6_duty_cleared", 32'(h0), 32'd0);
    run_cycles(1, h0, h1, tk);
    check("t6_fifo_discarded", 32'(underrun), 32'h3);
    check("t6_tick", 32'(tk), 32'd1);
    en = 1'b0;

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_dac_multi.md
Name: pwm_dac_multi

Overview:
Multi-channel PWM audio DAC and the parametrised successor to the single-channel PWM DAC. It runs in the PWM clock domain. Each channel has its own sample FIFO with a valid/ready write port. All channels share one period counter and a sample-rate divider. New samples are released into every channel's duty register at the same period boundary, and FIFO underruns are reported per channel with sticky flags.

Parameters:
WIDTH, 12, duty/sample width; PWM period = 2^WIDTH clk cycles
CHANNELS, 2, number of independent PWM outputs (>=1)
FIFO_DEPTH, 4, per-channel sample FIFO depth; power of 2, >=2
SAMPLE_DIV, 1, PWM periods per sample (>=1)

Ports:
clk  in  1  PWM clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable
wr_valid  in  CHANNELS  per-channel sample valid
wr_data  in  CHANNELS*WIDTH  samples; channel i = bits [i*WIDTH +: WIDTH]
wr_ready  out  CHANNELS  per-channel FIFO not full
clr_underrun  in  1  clears all underrun flags
pwm  out  CHANNELS  registered PWM outputs
underrun  out  CHANNELS  sticky per-channel underrun flags
sample_tick  out  1  one-cycle pulse on every sample load

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n, asynchronous and active-low.
- Reset values: pwm=0, underrun=0, sample_tick=0, all duty=0, all FIFOs empty, cnt=0, div=0.
- wr_ready is forced to 0 while rst_n=0. After reset, wr_ready[i] = !full[i].
- Period counter cnt (WIDTH bits):
  - en=1: increments every cycle, wrapping 2^WIDTH-1 -> 0.
  - en=0: cnt and div are held at 0 and pwm=0.
- Load boundary: en=1 and cnt=2^WIDTH-1 and div=SAMPLE_DIV-1.
  - div increments at each cnt wrap and wraps at SAMPLE_DIV-1.
  - At a load boundary, sample_tick=1 on the next cycle.
- At a load boundary, each channel independently:
  - FIFO non-empty: pop the head into duty[i]; the new duty governs from cnt=0.
  - FIFO empty: duty[i] holds its old value and underrun[i] is set.
- Output: pwm[i] <= en && (cnt < duty[i]), registered, so one cycle of latency from cnt.
  - duty=0 gives constant low.
  - duty=2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH cycles.
- Write: a push happens when wr_valid[i] && wr_ready[i]. Writes are accepted while en=0; there is no pop while en=0.
- Simultaneous events:
  - Full FIFO with a pop in the same cycle: wr_ready is still 0 that cycle, so no push.
  - Empty FIFO with a push and a load boundary in the same cycle: underrun is set, the push is stored, and the pop is not performed.
  - Underrun set and clr_underrun in the same cycle: set wins.
- FIFO: FIFO_DEPTH entries, pointers with an extra wrap bit for full/empty. Data is popped in write order. Channels are fully independent.
- Reset mid-operation: everything clears immediately. Pending FIFO data is discarded.

Decomposition:
- Shared package:
  - cnt width (WIDTH)
  - FIFO pointer width $clog2(FIFO_DEPTH)+1
  - div width $clog2(SAMPLE_DIV)+1
  - FIFO_DEPTH power-of-2 check
- Sub-module pwm_dac_channel (one per channel, generate loop), holding:
  - the FIFO
  - the duty register
  - the compare/pwm flop
  - the underrun flag
- The top level holds cnt, div, boundary detection, sample_tick and port slicing.

Test Plan:
(WIDTH=4, CHANNELS=2, FIFO_DEPTH=4, SAMPLE_DIV=1 unless stated)
1. Hold rst_n=0 -> pwm=00, wr_ready=00, underrun=00. Release rst_n -> wr_ready=11 next cycle.
2. Push 5 to ch0 and 12 to ch1, then en=1 -> after the first boundary, ch0 is high 5 of 16 cycles and ch1 is high 12 of 16 cycles. Pulses start 1 cycle after cnt=0. sample_tick pulses once per 16 cycles.
3. Push 1,2,3,4 into ch0 -> wr_ready[0]=0 and a 5th write is dropped. Successive periods show duty 1,2,3,4. wr_ready[0] returns to 1 after the first pop.
4. Let ch1 run empty at a boundary -> duty is held, underrun[1]=1 and stays 1 until a clr_underrun pulse; ch0 is unaffected. Assert set and clr in the same cycle -> the flag stays 1.
5. Duties 0 and 15 -> constant low, and low exactly 1 cycle per period. With SAMPLE_DIV=3, loads occur every 48 cycles.
6. Drop rst_n mid-period with a non-empty FIFO -> outputs and flags clear asynchronously. After release the FIFO is empty and the first boundary sets underrun.
